// File: rtl/imm_encoder.sv
// RV32I instruction assembler: places register fields and a signed immediate into
// an instruction word, rejects unencodable immediates and expands LI into LUI+ADDI.
module imm_encoder #(
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_err,
    output logic        out_last
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned LO_W    = 12;
    localparam int unsigned HI_W    = 20;

    localparam logic [2:0] FMT_ARITH  = 3'd0;
    localparam logic [2:0] FMT_JALR   = 3'd1;
    localparam logic [2:0] FMT_STORE  = 3'd2;
    localparam logic [2:0] FMT_BRANCH = 3'd3;
    localparam logic [2:0] FMT_LUI    = 3'd4;
    localparam logic [2:0] FMT_AUIPC  = 3'd5;
    localparam logic [2:0] FMT_JAL    = 3'd6;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic {
        IDLE,
        LI_LO
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               load_lo;
    logic [REG_W-1:0]   li_rd;
    logic [LO_W-1:0]    li_lo;

    logic [XLEN-1:0]    enc_word;
    logic               enc_err;
    logic               enc_last;
    logic               enc_li2;
    logic               fits12;
    logic               fits13;
    logic               fits21;
    logic               is_shift;
    logic               shamt_ok;
    logic [HI_W-1:0]    li_hi;

    // Immediate range/alignment checks and field scatter for the incoming request
    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        enc_last = 1'b1;
        enc_li2  = 1'b0;
        fits12   = (in_imm == {{20{in_imm[11]}}, in_imm[11:0]});
        fits13   = (in_imm == {{19{in_imm[12]}}, in_imm[12:0]});
        fits21   = (in_imm == {{11{in_imm[20]}}, in_imm[20:0]});
        is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
        shamt_ok = (in_imm[11:5] == 7'h00) ||
                   ((in_imm[11:5] == 7'h20) && (in_funct3 == 3'b101));
        // (imm + 0x800) >> 12 without carrying the unused low sum bits
        li_hi    = in_imm[31:12] + HI_W'(in_imm[11]);

        case (in_fmt)
            FMT_ARITH: begin
                enc_err  = !fits12 || (is_shift && !shamt_ok);
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
            end
            FMT_JALR: begin
                enc_err  = !fits12;
                enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
            end
            FMT_STORE: begin
                enc_err  = !fits12;
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            end
            FMT_BRANCH: begin
                enc_err  = !fits13 || in_imm[0];
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], OP_BRANCH};
            end
            FMT_LUI: begin
                enc_err  = (in_imm[11:0] != 12'h000);
                enc_word = {in_imm[31:12], in_rd, OP_LUI};
            end
            FMT_AUIPC: begin
                enc_err  = (in_imm[11:0] != 12'h000);
                enc_word = {in_imm[31:12], in_rd, OP_AUIPC};
            end
            FMT_JAL: begin
                enc_err  = !fits21 || in_imm[0];
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            end
            default: begin
                if (fits12) begin
                    enc_word = {in_imm[11:0], 5'd0, 3'b000, in_rd, OP_IMM};
                end else begin
                    enc_word = {li_hi, in_rd, OP_LUI};
                    enc_li2  = (in_imm[11:0] != 12'h000);
                    enc_last = !enc_li2;
                end
            end
        endcase

        if (enc_err) begin
            enc_word = NOP_WORD;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: LI_LO lasts until the LUI half leaves the output stage
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && enc_li2) state_nxt = LI_LO;
            LI_LO:   if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake decode
    always_comb begin
        in_ready = (state == IDLE) && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        load_lo  = (state == LI_LO) && out_valid && out_ready;
    end

    // Output stage and LI hold registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            out_err   <= 1'b0;
            out_last  <= 1'b0;
            li_rd     <= '0;
            li_lo     <= '0;
        end else if (load_lo) begin
            out_valid <= 1'b1;
            out_word  <= {li_lo, li_rd, 3'b000, li_rd, OP_IMM};
            out_err   <= 1'b0;
            out_last  <= 1'b1;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_word  <= enc_word;
            out_err   <= enc_err;
            out_last  <= enc_last;
            if (enc_li2) begin
                li_rd <= in_rd;
                li_lo <= in_imm[11:0];
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed plan cases plus randomized requests
// compared against an arithmetic reference model of the RV32I encodings.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_err;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    imm_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_err   (out_err),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: words the assembler should emit, from signed ranges and bit arithmetic
    function automatic void model(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                                  output int n, output logic [31:0] w0, output logic [31:0] w1,
                                  output logic err, output logic last0);
        int v;
        logic ok;
        logic [31:0] u;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] r_d;
        logic [31:0] r_s1;
        logic [31:0] r_s2;
        logic [31:0] fn3;
        v     = int'(imm);
        u     = imm;
        r_d   = 32'(rd) << 7;
        r_s1  = 32'(rs1) << 15;
        r_s2  = 32'(rs2) << 20;
        fn3   = 32'(f3) << 12;
        n     = 1;
        w1    = 32'h0;
        err   = 1'b0;
        last0 = 1'b1;
        ok    = 1'b1;
        w0    = 32'h0;
        case (f)
            3'd0: begin
                ok = (v >= -2048) && (v <= 2047);
                if (f3 == 3'd1) ok = ok && (((u >> 5) & 32'h7F) == 0);
                if (f3 == 3'd5) ok = ok && ((((u >> 5) & 32'h7F) == 0) || (((u >> 5) & 32'h7F) == 32'h20));
                w0 = ((u & 32'hFFF) << 20) | r_s1 | fn3 | r_d | 32'h13;
            end
            3'd1: begin
                ok = (v >= -2048) && (v <= 2047);
                w0 = ((u & 32'hFFF) << 20) | r_s1 | r_d | 32'h67;
            end
            3'd2: begin
                ok = (v >= -2048) && (v <= 2047);
                w0 = (((u >> 5) & 32'h7F) << 25) | r_s2 | r_s1 | fn3 | ((u & 32'h1F) << 7) | 32'h23;
            end
            3'd3: begin
                ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
                w0 = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | r_s2 | r_s1 | fn3 |
                     (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
            end
            3'd4: begin
                ok = (u % 4096) == 0;
                w0 = (u & 32'hFFFFF000) | r_d | 32'h37;
            end
            3'd5: begin
                ok = (u % 4096) == 0;
                w0 = (u & 32'hFFFFF000) | r_d | 32'h17;
            end
            3'd6: begin
                ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
                w0 = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20) |
                     (((u >> 12) & 32'hFF) << 12) | r_d | 32'h6F;
            end
            default: begin
                if ((v >= -2048) && (v <= 2047)) begin
                    w0 = ((u & 32'hFFF) << 20) | r_d | 32'h13;
                end else begin
                    hi = (u + 32'h800) >> 12;
                    lo = u & 32'hFFF;
                    w0 = (hi << 12) | r_d | 32'h37;
                    if (lo != 0) begin
                        n     = 2;
                        last0 = 1'b0;
                        w1    = (lo << 20) | (32'(rd) << 15) | r_d | 32'h13;
                    end
                end
            end
        endcase
        if (!ok) begin
            err = 1'b1;
            w0  = 32'h00000013;
        end
    endfunction

    // One request: accept, optional stall on first word, check every word, then idle
    task automatic run_req(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                           input int stall, input logic lit_en, input logic [31:0] lit0);
        int n;
        logic [31:0] w[2];
        logic e;
        logic l0;
        logic [31:0] ew;
        model(f, rd, rs1, rs2, f3, imm, n, w[0], w[1], e, l0);
        in_fmt    = f;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_imm    = imm;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        #1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (lit_en) begin
            #1;
            chk("plan_word", out_word, lit0);
        end
        for (int k = 0; k < n; k++) begin
            ew = w[k];
            for (int s = 0; s < ((k == 0) ? stall : 0); s++) begin
                out_ready = 1'b0;
                #1;
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_word", out_word, ew);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            #1;
            chk("valid", 32'(out_valid), 32'd1);
            chk("word", out_word, ew);
            chk("err", 32'(out_err), (k == 0) ? 32'(e) : 32'd0);
            chk("last", 32'(out_last), (k == n - 1) ? 32'd1 : 32'd0);
            chk("in_ready_out", 32'(in_ready), (n == 2 && k == 0) ? 32'd0 : 32'd1);
            @(negedge clk);
        end
        #1;
        chk("drained", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] imm;
        logic [31:0] r;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_fmt    = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_funct3 = '0;
        in_imm    = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_word", out_word, 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        run_req(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 0, 1'b1, 32'h00500093);
        run_req(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8, 0, 1'b1, 32'hFE208CE3);
        run_req(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 0, 1'b1, 32'h00000013);
        run_req(3'd0, 5'd3, 5'd3, 5'd0, 3'd5, 32'h404, 0, 1'b1, 32'h4041D193);
        run_req(3'd0, 5'd3, 5'd3, 5'd0, 3'd1, 32'h404, 0, 1'b1, 32'h00000013);
        run_req(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 0, 1'b1, 32'h001000EF);
        run_req(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 32'h100000, 0, 1'b1, 32'h00000013);
        run_req(3'd7, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345FFF, 0, 1'b1, 32'h123462B7);
        run_req(3'd7, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 0, 1'b1, 32'h123452B7);
        run_req(3'd7, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345FFF, 3, 1'b0, 32'h0);

        // Reset while the ADDI half is pending
        in_fmt    = 3'd7;
        in_rd     = 5'd7;
        in_imm    = 32'h12345FFF;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("li_pending_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_word", out_word, 32'd0);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        #1;
        run_req(3'd2, 5'd0, 5'd4, 5'd9, 3'd2, -32'sd20, 0, 1'b0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: imm = 32'($urandom_range(0, 32)) - 32'd16;
                1: imm = 32'($urandom_range(0, 10000)) - 32'd5000;
                2: imm = $urandom;
                3: imm = $urandom & 32'hFFFFF000;
                4: imm = {20'd0, ($urandom_range(0, 2) == 0) ? 7'h20 : 7'($urandom_range(0, 1)), 5'($urandom)};
                default: imm = 32'($urandom_range(0, 2200000)) - 32'd1100000;
            endcase
            run_req(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm,
                    $urandom_range(0, 2), 1'b0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
